// File: rtl/seg_scan_monitor.sv
// Scanned 7-segment bus monitor: recovers {dp, hex} codes per digit from an
// active-low segment/anode bus, flags unknown glyphs and strobes complete frames.
//
// state  | meaning
// IDLE   | no single active digit on the registered bus
// SETTLE | one digit active, counting identical samples toward capture
// HELD   | current digit/pattern already captured, waiting for a change
module seg_scan_monitor #(
   parameter int DIGITS        = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [7:0]            i_seg_n,
   input  logic [DIGITS-1:0]     i_an_n,
   input  logic                  i_clr,
   output logic [DIGITS*5-1:0]   o_codes,
   output logic [DIGITS-1:0]     o_digit_valid,
   output logic                  o_frame_valid,
   output logic                  o_frame_err,
   output logic                  o_bus_err
);

   localparam int         IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
   localparam logic [7:0] ONE    = 8'd1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } state_t;

   state_t              state, state_n;
   logic [7:0]          cnt, cnt_n, cnt_inc;
   logic [7:0]          seg_q, prev_seg;
   logic [DIGITS-1:0]   an_q;
   logic [IDX_W-1:0]    idx, prev_idx;
   logic [3:0]          low_cnt;
   logic                single, multi, same;
   logic [7:0]          s;
   logic [3:0]          hex;
   logic                glyph_hit, blank, unknown;
   logic [4:0]          cap_code;
   logic                capture;
   logic [DIGITS-1:0]   mask, mask_set;
   logic                err_acc;
   int                  slot_base;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         seg_q <= 8'hff;
         an_q  <= '1;
      end else begin
         seg_q <= i_seg_n;
         an_q  <= i_an_n;
      end
   end

   always_comb begin
      low_cnt = '0;
      idx     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!an_q[i]) begin
            low_cnt = low_cnt + 4'd1;
            idx     = IDX_W'(i);
         end
      end
   end

   // A multi-hot anode sample is reported but otherwise treated as idle.
   assign single = (low_cnt == 4'd1);
   assign multi  = (low_cnt > 4'd1);
   assign same   = (idx == prev_idx) && (seg_q == prev_seg);

   assign s = ~seg_q;

   always_comb begin
      glyph_hit = 1'b1;
      hex       = 4'h0;
      case (s[6:0])
         7'h3f: hex = 4'h0;
         7'h06: hex = 4'h1;
         7'h5b: hex = 4'h2;
         7'h4f: hex = 4'h3;
         7'h66: hex = 4'h4;
         7'h6d: hex = 4'h5;
         7'h7d: hex = 4'h6;
         7'h07: hex = 4'h7;
         7'h7f: hex = 4'h8;
         7'h6f: hex = 4'h9;
         7'h77: hex = 4'ha;
         7'h7c: hex = 4'hb;
         7'h39: hex = 4'hc;
         7'h5e: hex = 4'hd;
         7'h79: hex = 4'he;
         7'h71: hex = 4'hf;
         default: glyph_hit = 1'b0;
      endcase
   end

   // A lone decimal point is not blank, so it falls through to unknown.
   assign blank    = (s == 8'h00);
   assign unknown  = !glyph_hit && !blank;
   assign cap_code = glyph_hit ? {s[7], hex} : 5'h00;

   assign cnt_inc = (cnt >= STABLE) ? STABLE : cnt + ONE;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      capture = 1'b0;
      case (state)
         IDLE: begin
            if (single) begin
               cnt_n = ONE;
               if (ONE >= STABLE) begin
                  capture = 1'b1;
                  state_n = HELD;
               end else begin
                  state_n = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (!single) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (same) begin
               cnt_n = cnt_inc;
               if (cnt_inc >= STABLE) begin
                  capture = 1'b1;
                  state_n = HELD;
               end
            end else begin
               cnt_n = ONE;
               if (ONE >= STABLE) begin
                  capture = 1'b1;
                  state_n = HELD;
               end
            end
         end
         HELD: begin
            if (!single) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (!same) begin
               cnt_n = ONE;
               if (ONE >= STABLE) begin
                  capture = 1'b1;
                  state_n = HELD;
               end else begin
                  state_n = SETTLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         prev_idx <= '0;
         prev_seg <= 8'hff;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (single) begin
            prev_idx <= idx;
            prev_seg <= seg_q;
         end
      end
   end

   assign mask_set  = mask | (DIGITS'(1) << idx);
   assign slot_base = 5 * int'(idx);

   // Clear beats capture for frame bookkeeping, but captured codes still land.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_codes       <= '0;
         o_digit_valid <= '0;
         o_frame_valid <= 1'b0;
         o_frame_err   <= 1'b0;
         o_bus_err     <= 1'b0;
         mask          <= '0;
         err_acc       <= 1'b0;
      end else begin
         o_frame_valid <= 1'b0;
         o_frame_err   <= 1'b0;
         if (capture) begin
            o_codes[slot_base +: 5] <= cap_code;
            o_digit_valid[idx]      <= glyph_hit;
         end
         if (i_clr) begin
            mask      <= '0;
            err_acc   <= 1'b0;
            o_bus_err <= 1'b0;
         end else begin
            if (multi) begin
               o_bus_err <= 1'b1;
            end
            if (capture) begin
               if (&mask_set) begin
                  o_frame_valid <= 1'b1;
                  o_frame_err   <= err_acc | unknown;
                  mask          <= '0;
                  err_acc       <= 1'b0;
               end else begin
                  mask    <= mask_set;
                  err_acc <= err_acc | unknown;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Directed bench for seg_scan_monitor (4 digits, 4-sample dwell); expected frames
// are queued by the stimulus and checked by a monitor on every frame strobe.
module tb_seg_scan_monitor;

   localparam int DIGITS = 4;
   localparam int STABLE = 4;

   logic                  i_clk   = 1'b0;
   logic                  i_rst_n = 1'b0;
   logic [7:0]            i_seg_n = 8'hff;
   logic [DIGITS-1:0]     i_an_n  = '1;
   logic                  i_clr   = 1'b0;
   logic [DIGITS*5-1:0]   o_codes;
   logic [DIGITS-1:0]     o_digit_valid;
   logic                  o_frame_valid;
   logic                  o_frame_err;
   logic                  o_bus_err;

   seg_scan_monitor #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_seg_n       (i_seg_n),
      .i_an_n        (i_an_n),
      .i_clr         (i_clr),
      .o_codes       (o_codes),
      .o_digit_valid (o_digit_valid),
      .o_frame_valid (o_frame_valid),
      .o_frame_err   (o_frame_err),
      .o_bus_err     (o_bus_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [19:0] codes;
      logic [3:0]  dv;
      logic        err;
   } frame_t;

   frame_t sb[$];
   frame_t exp_f;
   int     checks   = 0;
   int     failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   // Inputs change on the falling edge and stay for n rising edges.
   task automatic hold(input logic [3:0] an, input logic [7:0] seg_on, input int n);
      i_an_n  = an;
      i_seg_n = ~seg_on;
      repeat (n) @(negedge i_clk);
   endtask

   task automatic dig(input int k, input logic [7:0] pat, input int n);
      logic [3:0] an;
      an = ~(4'b0001 << k);
      hold(an, pat, n);
   endtask

   task automatic idle(input int n);
      hold(4'hf, 8'h00, n);
   endtask

   task automatic scan4(input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic [7:0] p3);
      dig(0, p0, 8);
      dig(1, p1, 8);
      dig(2, p2, 8);
      dig(3, p3, 8);
      idle(3);
   endtask

   task automatic expect_frame(input logic [19:0] codes, input logic [3:0] dv, input logic err);
      frame_t f;
      f.codes = codes;
      f.dv    = dv;
      f.err   = err;
      sb.push_back(f);
   endtask

   task automatic clr_pulse();
      i_clr = 1'b1;
      @(negedge i_clk);
      i_clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      fork
         forever begin
            @(negedge i_clk);
            if (o_frame_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL frame_unexpected actual codes=%0h expected=no_frame", o_codes);
               end else begin
                  exp_f = sb.pop_front();
                  chk("frame_codes", 32'(o_codes), 32'(exp_f.codes));
                  chk("frame_digit_valid", 32'(o_digit_valid), 32'(exp_f.dv));
                  chk("frame_err", 32'(o_frame_err), 32'(exp_f.err));
               end
            end
         end
      join_none

      repeat (3) @(negedge i_clk);
      chk("rst_codes", 32'(o_codes), 32'h0);
      chk("rst_digit_valid", 32'(o_digit_valid), 32'h0);
      chk("rst_frame_valid", 32'(o_frame_valid), 32'h0);
      chk("rst_frame_err", 32'(o_frame_err), 32'h0);
      chk("rst_bus_err", 32'(o_bus_err), 32'h0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Basic capture latency: update lands after the 5th edge.
      hold(4'b1110, 8'h5b, 4);
      chk("basic_valid_before", 32'(o_digit_valid[0]), 32'h0);
      hold(4'b1110, 8'h5b, 1);
      chk("basic_code", 32'(o_codes[4:0]), 32'h02);
      chk("basic_valid", 32'(o_digit_valid[0]), 32'h1);
      hold(4'b1110, 8'h5b, 1);
      idle(2);
      clr_pulse();

      // Full frame: "1", "A.", blank, "F".
      expect_frame({5'h0f, 5'h00, 5'h1a, 5'h01}, 4'b1011, 1'b0);
      scan4(8'h06, 8'hf7, 8'h00, 8'h71);
      chk("frame_codes_after", 32'(o_codes), 32'({5'h0f, 5'h00, 5'h1a, 5'h01}));

      // Unknown glyph on digit 2.
      expect_frame({5'h0f, 5'h00, 5'h1a, 5'h01}, 4'b1011, 1'b1);
      scan4(8'h06, 8'hf7, 8'h49, 8'h71);

      // Glitch: "1" for 3 samples on digit 1 must never be captured.
      expect_frame({5'h0f, 5'h00, 5'h03, 5'h01}, 4'b1011, 1'b0);
      dig(0, 8'h06, 8);
      dig(1, 8'h06, 3);
      dig(1, 8'h4f, 2);
      chk("glitch_slot1_kept", 32'(o_codes[9:5]), 32'h1a);
      dig(1, 8'h4f, 3);
      chk("glitch_slot1_new", 32'(o_codes[9:5]), 32'h03);
      dig(2, 8'h00, 8);
      dig(3, 8'h71, 8);
      idle(3);

      // Partial frame on digits 1..3, then bus error and clear.
      dig(1, 8'h7f, 8);
      dig(2, 8'h7f, 8);
      dig(3, 8'h7f, 8);
      hold(4'b1100, 8'h06, 1);
      chk("bus_err_latency", 32'(o_bus_err), 32'h0);
      idle(1);
      chk("bus_err_set", 32'(o_bus_err), 32'h1);
      chk("bus_err_no_capture_codes", 32'(o_codes), 32'({5'h08, 5'h08, 5'h08, 5'h01}));
      chk("bus_err_no_capture_valid", 32'(o_digit_valid), 32'hf);
      idle(2);
      clr_pulse();
      chk("bus_err_cleared", 32'(o_bus_err), 32'h0);
      expect_frame({5'h05, 5'h04, 5'h03, 5'h02}, 4'b1111, 1'b0);
      scan4(8'h5b, 8'h4f, 8'h66, 8'h6d);

      // Asynchronous reset after two captures, including an unknown one.
      dig(0, 8'h71, 8);
      dig(1, 8'h49, 8);
      dig(2, 8'h06, 3);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("arst_codes", 32'(o_codes), 32'h0);
      chk("arst_digit_valid", 32'(o_digit_valid), 32'h0);
      chk("arst_frame_valid", 32'(o_frame_valid), 32'h0);
      chk("arst_frame_err", 32'(o_frame_err), 32'h0);
      chk("arst_bus_err", 32'(o_bus_err), 32'h0);
      i_an_n  = 4'hf;
      i_seg_n = 8'hff;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      expect_frame({5'h07, 5'h0e, 5'h0c, 5'h09}, 4'b1111, 1'b0);
      scan4(8'h6f, 8'h39, 8'h79, 8'h07);

      idle(4);
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
